pipeline_mem_arbiter: RTL and testbench
=======================================

Name: pipeline_mem_arbiter

Overview:
- Shares one single-port memory between the fetch stage (imem) and the memory stage (dmem) of the RV32I pipeline.
- Arbitrates between the two ports and issues exactly one memory transaction at a time.
- Routes the response back to the owning requester.
- Drops in-flight fetches on a front-end flush.
- Dmem has fixed priority, with a starvation guard for imem.

Parameters:
- MAX_D_STREAK, 4: maximum consecutive dmem grants while an imem request is waiting. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- imem_addr  in  32  fetch address, word aligned
- imem_rmask  in  4  fetch byte mask; nonzero means request
- imem_rdata  out  32  fetch data
- imem_resp  out  1  fetch complete, one-cycle pulse
- dmem_addr  in  32  load/store address
- dmem_rmask  in  4  load byte mask
- dmem_wmask  in  4  store byte mask; request = (rmask|wmask) != 0
- dmem_wdata  in  32  store data
- dmem_rdata  out  32  load data
- dmem_resp  out  1  load/store complete, one-cycle pulse
- mem_addr  out  32  memory address
- mem_rmask  out  4  memory read mask
- mem_wmask  out  4  memory write mask
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- mem_resp  in  1  memory completion, one-cycle pulse
- if_flush  in  1  front-end flush (branch/jump redirect)
- busy  out  1  a transaction is issued or outstanding

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0:
  - State is IDLE, d_streak is 0.
  - All mem_* outputs are 0; imem_resp=0, dmem_resp=0, busy=0.
  - imem_rdata and dmem_rdata are 0.
  - Reset mid-transaction abandons the transaction; no resp is produced afterwards.
- Requester contract: a requester holds addr, masks and wdata stable from assertion until the cycle its resp is high, then may change them.
- States: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D, DROP_I.
- IDLE: requests are sampled only in IDLE. Grant decision:
  - dmem only -> ISSUE_D.
  - imem only and if_flush=0 -> ISSUE_I.
  - both pending and if_flush=0 -> imem if d_streak==MAX_D_STREAK, else dmem.
  - imem request with if_flush=1 is not granted that cycle.
  - On grant, the request fields are registered into the mem_* output registers.
- ISSUE_x: lasts exactly one cycle.
  - mem_rmask/mem_wmask are nonzero; mem_addr/mem_wdata are valid.
  - Next state is WAIT_x.
  - If mem_resp is also high in this cycle, treat it as completion (zero-wait memory).
- WAIT_x:
  - mem_rmask=mem_wmask=0; mem_addr/mem_wdata hold their last values.
  - Stay until mem_resp=1.
  - On mem_resp: x_resp=1 combinationally in the same cycle, and x_rdata=mem_rdata. Next state is IDLE.
- DROP_I:
  - Entered from ISSUE_I or WAIT_I when if_flush=1.
  - Waits for mem_resp with imem_resp held 0, then goes to IDLE.
  - mem_resp arriving in the flush cycle itself is also dropped; go directly to IDLE.
- imem_resp is never asserted in a cycle where if_flush=1.
- The rdata outputs for the non-owner port hold their previous value.
- mem_resp received in IDLE is ignored.
- Latency: request first seen in IDLE at cycle 0; memory mask is active at cycle 1; resp returns in the same cycle as mem_resp. Minimum latency is 2 cycles. Each transaction has 1 IDLE cycle of turnaround, so the back-to-back throughput is 1 transaction per (memory latency + 2) cycles.
- d_streak (4 bits):
  - +1 (saturating at MAX_D_STREAK) on a dmem grant while an imem request is pending and unflushed.
  - Cleared on any imem grant.
  - Cleared on a dmem grant with no imem pending.
- busy = (state != IDLE).
- Writes: dmem_resp pulses on write completion; dmem_rdata is then don't-care but still updated from mem_rdata.

Test Plan:
- Single fetch: imem_addr=0x6000_0000, rmask=0xF; memory responds 3 cycles after issue with 0x0000_0013 -> mem_rmask=0xF for exactly one cycle at cycle 1; imem_resp=1 with imem_rdata=0x13 at cycle 4; dmem_resp stays 0.
- Conflict: imem and dmem requests both asserted at cycle 0, dmem store wmask=0x3, addr=0x6000_0104, wdata=0xBEEF -> dmem issued first (mem_wmask=0x3); imem issued in the IDLE cycle after dmem_resp.
- Starvation guard with MAX_D_STREAK=2: continuous dmem loads plus a waiting imem -> grant order D,D,I,D,D,I; d_streak returns to 0 after each I grant.
- Flush during WAIT_I: pulse if_flush 1 cycle before mem_resp -> imem_resp never asserted; state returns to IDLE after mem_resp; a new fetch to 0x6000_0040 then completes normally.
- Zero-wait memory: mem_resp=1 in the ISSUE_D cycle with mem_rdata=0x1234_5678 -> dmem_resp=1 and dmem_rdata=0x1234_5678 in that cycle; next state IDLE.
- Reset mid-WAIT_D: drop rst_n asynchronously -> all outputs 0 immediately; a late mem_resp after release produces no resp; busy=0.

Source files
------------

// File: rtl/pipeline_mem_arbiter.sv
// -----------------------------------------------------------------------------
// pipeline_mem_arbiter
//   Shares one single-port memory between the fetch stage (imem) and the
//   memory stage (dmem) of an RV32I pipeline. One transaction is in flight at
//   a time. Dmem wins conflicts, but after MAX_D_STREAK consecutive dmem grants
//   with a fetch waiting, the fetch is granted. A front-end flush drops an
//   in-flight fetch so its response never reaches the fetch stage.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_addr_i/rmask_i        fetch request (rmask != 0 means request)
//   imem_rdata_o/resp_o        fetch data and one-cycle completion pulse
//   dmem_addr_i/rmask_i/
//   wmask_i/wdata_i            load/store request ((rmask|wmask) != 0)
//   dmem_rdata_o/resp_o        load data and one-cycle completion pulse
//   mem_addr_o/rmask_o/
//   wmask_o/wdata_o            registered request towards the memory
//   mem_rdata_i/resp_i         memory read data and completion pulse
//   if_flush_i                 front-end redirect
//   busy_o                     a transaction is issued or outstanding
// -----------------------------------------------------------------------------
module pipeline_mem_arbiter #(
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_addr_i,
    input  logic [3:0]  imem_rmask_i,
    output logic [31:0] imem_rdata_o,
    output logic        imem_resp_o,
    input  logic [31:0] dmem_addr_i,
    input  logic [3:0]  dmem_rmask_i,
    input  logic [3:0]  dmem_wmask_i,
    input  logic [31:0] dmem_wdata_i,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_resp_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_rmask_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_resp_i,
    input  logic        if_flush_i,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        WAIT_I  = 3'd3,
        WAIT_D  = 3'd4,
        DROP_I  = 3'd5
    } state_e;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    state_e      state_q, state_d;
    logic [3:0]  d_streak_q, d_streak_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_rmask_q, mem_rmask_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] imem_rdata_q, dmem_rdata_q;

    logic i_req_s, d_req_s, i_live_s, streak_full_s;
    logic grant_i_s, grant_d_s, imem_resp_s, dmem_resp_s;

    assign i_req_s       = (imem_rmask_i != 4'h0);
    assign d_req_s       = ((dmem_rmask_i | dmem_wmask_i) != 4'h0);
    // A fetch only competes for the memory when it is not being flushed.
    assign i_live_s      = i_req_s && !if_flush_i;
    assign streak_full_s = (d_streak_q == MAX_STREAK);

    // Next-state, grant and response-routing decode.
    always_comb begin
        state_d     = state_q;
        grant_i_s   = 1'b0;
        grant_d_s   = 1'b0;
        imem_resp_s = 1'b0;
        dmem_resp_s = 1'b0;
        case (state_q)
            IDLE: begin
                // Dmem wins unless a live fetch has waited out the streak.
                if (d_req_s && !(i_live_s && streak_full_s)) begin
                    grant_d_s = 1'b1;
                    state_d   = ISSUE_D;
                end else if (i_live_s) begin
                    grant_i_s = 1'b1;
                    state_d   = ISSUE_I;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE_I, WAIT_I: begin
                // A flush kills the fetch; a response in the flush cycle
                // itself is swallowed and the memory is free again.
                if (if_flush_i) begin
                    state_d = mem_resp_i ? IDLE : DROP_I;
                end else if (mem_resp_i) begin
                    imem_resp_s = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = WAIT_I;
                end
            end
            ISSUE_D, WAIT_D: begin
                if (mem_resp_i) begin
                    dmem_resp_s = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = WAIT_D;
                end
            end
            DROP_I: begin
                if (mem_resp_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DROP_I;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Starvation counter and memory request register next-state.
    always_comb begin
        d_streak_d  = d_streak_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rmask_d = 4'h0;
        mem_wmask_d = 4'h0;
        if (grant_d_s) begin
            mem_addr_d  = dmem_addr_i;
            mem_rmask_d = dmem_rmask_i;
            mem_wmask_d = dmem_wmask_i;
            mem_wdata_d = dmem_wdata_i;
            if (i_live_s) begin
                d_streak_d = streak_full_s ? d_streak_q : d_streak_q + 4'd1;
            end else if (!i_req_s) begin
                d_streak_d = 4'd0;
            end else begin
                d_streak_d = d_streak_q;
            end
        end else if (grant_i_s) begin
            mem_addr_d  = imem_addr_i;
            mem_rmask_d = imem_rmask_i;
            mem_wmask_d = 4'h0;
            mem_wdata_d = 32'h0;
            d_streak_d  = 4'd0;
        end else begin
            d_streak_d = d_streak_q;
        end
    end

    // FSM state and starvation counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            d_streak_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            d_streak_q <= d_streak_d;
        end
    end

    // Memory-side request registers; masks are live only in ISSUE_x.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_q  <= 32'h0;
            mem_rmask_q <= 4'h0;
            mem_wmask_q <= 4'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            mem_addr_q  <= mem_addr_d;
            mem_rmask_q <= mem_rmask_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Read data holding registers; each port keeps its last returned word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_rdata_q <= 32'h0;
            dmem_rdata_q <= 32'h0;
        end else begin
            if (imem_resp_s) begin
                imem_rdata_q <= mem_rdata_i;
            end
            if (dmem_resp_s) begin
                dmem_rdata_q <= mem_rdata_i;
            end
        end
    end

    // Responses are combinational so data reaches the owner in the
    // same cycle the memory completes.
    assign imem_resp_o  = imem_resp_s;
    assign dmem_resp_o  = dmem_resp_s;
    assign imem_rdata_o = imem_resp_s ? mem_rdata_i : imem_rdata_q;
    assign dmem_rdata_o = dmem_resp_s ? mem_rdata_i : dmem_rdata_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_rmask_o  = mem_rmask_q;
    assign mem_wmask_o  = mem_wmask_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
module tb_pipeline_mem_arbiter;

    logic        clk, rst_n;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask, mem_rmask, mem_wmask;
    logic        imem_resp, dmem_resp, mem_resp, if_flush, busy;

    int checks = 0;
    int errors = 0;
    int mem_lat = 3;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } iss_t;

    iss_t        exp_iss[$];
    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] last_i = 32'h0;
    logic [31:0] last_d = 32'h0;

    pipeline_mem_arbiter #(.MAX_D_STREAK(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_addr_i(imem_addr), .imem_rmask_i(imem_rmask),
        .imem_rdata_o(imem_rdata), .imem_resp_o(imem_resp),
        .dmem_addr_i(dmem_addr), .dmem_rmask_i(dmem_rmask),
        .dmem_wmask_i(dmem_wmask), .dmem_wdata_i(dmem_wdata),
        .dmem_rdata_o(dmem_rdata), .dmem_resp_o(dmem_resp),
        .mem_addr_o(mem_addr), .mem_rmask_o(mem_rmask),
        .mem_wmask_o(mem_wmask), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp),
        .if_flush_i(if_flush), .busy_o(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] resp_data(input logic [31:0] a);
        if (a == 32'h6000_0000) return 32'h0000_0013;
        else if (a == 32'h6000_0200) return 32'h1234_5678;
        else return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic void push_iss(input logic [31:0] a, input logic [3:0] rm,
                                     input logic [3:0] wm, input logic [31:0] wd);
        iss_t e;
        e.addr = a; e.rmask = rm; e.wmask = wm; e.wdata = wd;
        exp_iss.push_back(e);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: answers each issued request mem_lat cycles after issue.
    initial begin
        logic [31:0] a;
        mem_resp  = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && (mem_rmask != 4'h0 || mem_wmask != 4'h0)) begin
                a = mem_addr;
                if (mem_lat != 0) begin
                    repeat (mem_lat) @(posedge clk);
                    #1;
                end
                mem_rdata = resp_data(a);
                mem_resp  = 1'b1;
                @(posedge clk);
                #1;
                mem_resp = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT issues or responds.
    initial begin
        iss_t e;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (mem_rmask != 4'h0 || mem_wmask != 4'h0) begin
                    if (exp_iss.size() == 0) begin
                        chk("unexpected_issue", mem_addr, 32'hxxxx_xxxx);
                    end else begin
                        e = exp_iss.pop_front();
                        chk("issue_addr", mem_addr, e.addr);
                        chk("issue_rmask", {28'h0, mem_rmask}, {28'h0, e.rmask});
                        chk("issue_wmask", {28'h0, mem_wmask}, {28'h0, e.wmask});
                        if (e.wmask != 4'h0) chk("issue_wdata", mem_wdata, e.wdata);
                    end
                end
                if (imem_resp) begin
                    chk("imem_resp_in_flush", {31'h0, if_flush}, 32'h0);
                    if (exp_i.size() == 0) begin
                        chk("unexpected_imem_resp", imem_rdata, 32'hxxxx_xxxx);
                    end else begin
                        d = exp_i.pop_front();
                        chk("imem_rdata", imem_rdata, d);
                        chk("dmem_rdata_hold", dmem_rdata, last_d);
                        last_i = d;
                    end
                end
                if (dmem_resp) begin
                    if (exp_d.size() == 0) begin
                        chk("unexpected_dmem_resp", dmem_rdata, 32'hxxxx_xxxx);
                    end else begin
                        d = exp_d.pop_front();
                        chk("dmem_rdata", dmem_rdata, d);
                        chk("imem_rdata_hold", imem_rdata, last_i);
                        last_d = d;
                    end
                end
            end
        end
    end

    task automatic imem_fetch(input logic [31:0] a);
        bit got = 1'b0;
        int k = 0;
        imem_addr  = a;
        imem_rmask = 4'hF;
        while (!got && k < 100) begin
            @(negedge clk);
            got = imem_resp;
            k++;
        end
        if (!got) chk("imem_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        imem_rmask = 4'h0;
    endtask

    task automatic dmem_op(input logic [31:0] a, input logic [3:0] rm,
                           input logic [3:0] wm, input logic [31:0] wd);
        bit got = 1'b0;
        int k = 0;
        dmem_addr  = a;
        dmem_rmask = rm;
        dmem_wmask = wm;
        dmem_wdata = wd;
        while (!got && k < 100) begin
            @(negedge clk);
            got = dmem_resp;
            k++;
        end
        if (!got) chk("dmem_timeout", 32'h0, 32'h1);
        @(posedge clk);
        #1;
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_mem_addr"}, mem_addr, 32'h0);
        chk({nm, "_mem_masks"}, {24'h0, mem_rmask, mem_wmask}, 32'h0);
        chk({nm, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({nm, "_resps_busy"}, {29'h0, imem_resp, dmem_resp, busy}, 32'h0);
        chk({nm, "_imem_rdata"}, imem_rdata, 32'h0);
        chk({nm, "_dmem_rdata"}, dmem_rdata, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_flush = 1'b0;
        imem_addr = 32'h0; imem_rmask = 4'h0;
        dmem_addr = 32'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        repeat (2) step();

        // Single fetch, memory answers 3 cycles after issue.
        mem_lat = 3;
        push_iss(32'h6000_0000, 4'hF, 4'h0, 32'h0);
        exp_i.push_back(32'h0000_0013);
        step(); imem_addr = 32'h6000_0000; imem_rmask = 4'hF;   // cycle 0
        @(negedge clk); chk("c0_busy", {31'h0, busy}, 32'h0);
        step(); @(negedge clk);                                    // cycle 1
        chk("c1_rmask", {28'h0, mem_rmask}, 32'hF);
        chk("c1_busy", {31'h0, busy}, 32'h1);
        step(); @(negedge clk);                                    // cycle 2
        chk("c2_rmask", {28'h0, mem_rmask}, 32'h0);
        step(); @(negedge clk);                                    // cycle 3
        chk("c3_imem_resp", {31'h0, imem_resp}, 32'h0);
        step(); @(negedge clk);                                    // cycle 4
        chk("c4_resps", {30'h0, imem_resp, dmem_resp}, 32'h2);
        step(); imem_rmask = 4'h0; @(negedge clk);                 // cycle 5
        chk("c5_busy", {31'h0, busy}, 32'h0);
        repeat (2) step();

        // Conflict: store wins, fetch follows.
        mem_lat = 2;
        push_iss(32'h6000_0104, 4'h0, 4'h3, 32'h0000_BEEF);
        push_iss(32'h6000_0004, 4'hF, 4'h0, 32'h0);
        exp_d.push_back(32'hC5A5_5B5E);
        exp_i.push_back(32'hC5A5_5A5E);
        step();
        fork
            dmem_op(32'h6000_0104, 4'h0, 4'h3, 32'h0000_BEEF);
            imem_fetch(32'h6000_0004);
        join
        repeat (2) step();

        // Starvation guard with MAX_D_STREAK=2: D,D,I,D,D,I.
        mem_lat = 1;
        push_iss(32'h6000_0100, 4'hF, 4'h0, 32'h0);
        push_iss(32'h6000_0110, 4'hF, 4'h0, 32'h0);
        push_iss(32'h6000_0008, 4'hF, 4'h0, 32'h0);
        push_iss(32'h6000_0120, 4'hF, 4'h0, 32'h0);
        push_iss(32'h6000_0130, 4'hF, 4'h0, 32'h0);
        push_iss(32'h6000_000C, 4'hF, 4'h0, 32'h0);
        exp_d.push_back(32'hC5A5_5B5A);
        exp_d.push_back(32'hC5A5_5B4A);
        exp_d.push_back(32'hC5A5_5B7A);
        exp_d.push_back(32'hC5A5_5B6A);
        exp_i.push_back(32'hC5A5_5A52);
        exp_i.push_back(32'hC5A5_5A56);
        step();
        fork
            begin
                dmem_op(32'h6000_0100, 4'hF, 4'h0, 32'h0);
                dmem_op(32'h6000_0110, 4'hF, 4'h0, 32'h0);
                dmem_op(32'h6000_0120, 4'hF, 4'h0, 32'h0);
                dmem_op(32'h6000_0130, 4'hF, 4'h0, 32'h0);
            end
            begin
                imem_fetch(32'h6000_0008);
                imem_fetch(32'h6000_000C);
            end
        join
        repeat (2) step();

        // Flush during WAIT_I, one cycle before mem_resp.
        mem_lat = 3;
        push_iss(32'h6000_0010, 4'hF, 4'h0, 32'h0);
        push_iss(32'h6000_0040, 4'hF, 4'h0, 32'h0);
        exp_i.push_back(32'hC5A5_5A1A);
        step(); imem_addr = 32'h6000_0010; imem_rmask = 4'hF;    // cycle 0
        step(); step();                                            // cycle 2
        step(); if_flush = 1'b1; imem_addr = 32'h6000_0040;       // cycle 3
        @(negedge clk); chk("fl3_imem_resp", {31'h0, imem_resp}, 32'h0);
        step(); if_flush = 1'b0;                                   // cycle 4
        @(negedge clk);
        chk("fl4_imem_resp", {31'h0, imem_resp}, 32'h0);
        chk("fl4_busy", {31'h0, busy}, 32'h1);
        step(); @(negedge clk);                                    // cycle 5
        chk("fl5_busy", {31'h0, busy}, 32'h0);
        imem_fetch(32'h6000_0040);
        repeat (2) step();

        // Zero-wait memory on a load.
        mem_lat = 0;
        push_iss(32'h6000_0200, 4'hF, 4'h0, 32'h0);
        exp_d.push_back(32'h1234_5678);
        step(); dmem_addr = 32'h6000_0200; dmem_rmask = 4'hF;     // cycle 0
        step(); @(negedge clk);                                    // cycle 1
        chk("zw_dmem_resp", {31'h0, dmem_resp}, 32'h1);
        chk("zw_dmem_rdata", dmem_rdata, 32'h1234_5678);
        step(); dmem_rmask = 4'h0; @(negedge clk);                 // cycle 2
        chk("zw_idle", {30'h0, busy, dmem_resp}, 32'h0);
        repeat (2) step();

        // Reset in the middle of WAIT_D; the late mem_resp is ignored.
        mem_lat = 4;
        push_iss(32'h6000_0300, 4'hF, 4'h0, 32'h0);
        step(); dmem_addr = 32'h6000_0300; dmem_rmask = 4'hF;     // cycle 0
        step(); step();                                            // cycle 2
        #2;
        rst_n = 1'b0;
        dmem_rmask = 4'h0;
        #1;
        chk_all_zero("mid_reset");
        last_i = 32'h0;
        last_d = 32'h0;
        step(); rst_n = 1'b1;                                      // cycle 3
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_reset_quiet", {30'h0, busy, dmem_resp}, 32'h0);
        end
        repeat (2) step();

        chk("left_issue", exp_iss.size(), 32'h0);
        chk("left_imem", exp_i.size(), 32'h0);
        chk("left_dmem", exp_d.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
